// File: rtl/freq_sweep_ctrl.sv
// Frequency-sweep sequencer for the SW-programmable ring-oscillator divider.
// Drives the divider's ld/SW and reloads on every carry so each period is exactly 512-64*code clocks.
module freq_sweep_ctrl #(
    parameter int DWELL_W = 8,
    parameter int CODE_W  = 3
) (
    input  logic               RO_Clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [CODE_W-1:0]  start_code,
    input  logic [CODE_W-1:0]  end_code,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               co_in,
    output logic               ld,
    output logic [CODE_W-1:0]  SW_out,
    output logic               busy,
    output logic               done,
    output logic               step_pulse,
    output logic [DWELL_W-1:0] period_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [CODE_W-1:0]  CODE_ONE  = CODE_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t             state_reg, state_next;
    logic [CODE_W-1:0]  code_reg, code_next;
    logic [CODE_W-1:0]  start_cap_reg, start_cap_next;
    logic [CODE_W-1:0]  end_cap_reg, end_cap_next;
    logic [DWELL_W-1:0] dwell_cap_reg, dwell_cap_next;
    logic               dir_up_reg, dir_up_next;
    logic               loop_cap_reg, loop_cap_next;
    logic [DWELL_W-1:0] period_cnt_reg, period_cnt_next;
    logic               step_pulse_reg, step_pulse_next;

    logic               capture;
    logic               final_carry;
    logic               at_end;
    logic [CODE_W-1:0]  step_code;

    always_ff @(posedge RO_Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            code_reg       <= '0;
            start_cap_reg  <= '0;
            end_cap_reg    <= '0;
            dwell_cap_reg  <= '0;
            dir_up_reg     <= 1'b0;
            loop_cap_reg   <= 1'b0;
            period_cnt_reg <= '0;
            step_pulse_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            code_reg       <= code_next;
            start_cap_reg  <= start_cap_next;
            end_cap_reg    <= end_cap_next;
            dwell_cap_reg  <= dwell_cap_next;
            dir_up_reg     <= dir_up_next;
            loop_cap_reg   <= loop_cap_next;
            period_cnt_reg <= period_cnt_next;
            step_pulse_reg <= step_pulse_next;
        end
    end

    // Captured dwell is never 0, so dwell_cap_reg-1 cannot underflow.
    assign final_carry = (state_reg == RUN) && co_in &&
                         (period_cnt_reg == (dwell_cap_reg - DWELL_ONE));
    assign at_end      = (code_reg == end_cap_reg);
    assign step_code   = at_end ? start_cap_reg :
                         (dir_up_reg ? code_reg + CODE_ONE : code_reg - CODE_ONE);

    always_comb begin
        state_next      = state_reg;
        code_next       = code_reg;
        start_cap_next  = start_cap_reg;
        end_cap_next    = end_cap_reg;
        dwell_cap_next  = dwell_cap_reg;
        dir_up_next     = dir_up_reg;
        loop_cap_next   = loop_cap_reg;
        period_cnt_next = period_cnt_reg;
        step_pulse_next = 1'b0;
        capture         = 1'b0;
        ld              = 1'b1;
        SW_out          = code_reg;
        busy            = 1'b0;
        done            = 1'b0;

        case (state_reg)
            IDLE: begin
                SW_out  = start_code;
                capture = start && !stop;
            end
            LOAD: begin
                busy       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                ld   = co_in;
                if (co_in && !stop) begin
                    if (final_carry) begin
                        period_cnt_next = '0;
                        if (!at_end || loop_cap_reg) begin
                            // Present the new code on the carry itself so the reload picks it up.
                            SW_out          = step_code;
                            code_next       = step_code;
                            step_pulse_next = 1'b1;
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        period_cnt_next = period_cnt_reg + DWELL_ONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                SW_out  = end_cap_reg;
                capture = start && !stop;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (capture) begin
            state_next      = LOAD;
            start_cap_next  = start_code;
            end_cap_next    = end_code;
            dwell_cap_next  = (dwell == '0) ? DWELL_ONE : dwell;
            dir_up_next     = (end_code >= start_code);
            loop_cap_next   = loop_en;
            code_next       = start_code;
            period_cnt_next = '0;
        end

        if (stop) begin
            state_next      = IDLE;
            period_cnt_next = '0;
            step_pulse_next = 1'b0;
        end
    end

    assign step_pulse = step_pulse_reg;
    assign period_cnt = period_cnt_reg;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl with a behavioural 9-bit divider attached; carries are
// scored against a queue of expected periods/codes pushed before each sweep.
module tb_freq_sweep_ctrl;

    logic       RO_Clk = 1'b0;
    logic       rst_n;
    logic       start, stop, loop_en;
    logic [2:0] start_code, end_code;
    logic [7:0] dwell;
    logic       co;
    logic       ld;
    logic [2:0] SW_out;
    logic       busy, done, step_pulse;
    logic [7:0] period_cnt;

    always #5 RO_Clk = ~RO_Clk;

    freq_sweep_ctrl #(.DWELL_W(8), .CODE_W(3)) dut (
        .RO_Clk     (RO_Clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .start_code (start_code),
        .end_code   (end_code),
        .dwell      (dwell),
        .co_in      (co),
        .ld         (ld),
        .SW_out     (SW_out),
        .busy       (busy),
        .done       (done),
        .step_pulse (step_pulse),
        .period_cnt (period_cnt)
    );

    // Divider: load {SW,6'b0}, count up, carry at all-ones.
    logic [8:0] div_cnt = 9'd0;
    always @(posedge RO_Clk) div_cnt <= ld ? {SW_out, 6'b0} : div_cnt + 9'd1;
    assign co = &div_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int period;
        int sw;
        bit step;
        bit dn;
        bit bz;
        int pc;
    } carry_t;

    carry_t sb[$];

    task automatic push(input int p, input int sw, input bit st, input bit dn, input bit bz, input int pc);
        carry_t r;
        r.period = p; r.sw = sw; r.step = st; r.dn = dn; r.bz = bz; r.pc = pc;
        sb.push_back(r);
    endtask

    // Carry monitor: period length, ld and SW_out on the carry; flags one cycle later.
    int     cyc = 0;
    bit     busy_q = 1'b0;
    bit     pend = 1'b0;
    carry_t pend_rec;
    carry_t cur;
    int     ncarry = 0;

    always @(negedge RO_Clk) begin
        if (pend) begin
            check("step_pulse_after_carry", int'(step_pulse), int'(pend_rec.step));
            check("done_after_carry", int'(done), int'(pend_rec.dn));
            check("busy_after_carry", int'(busy), int'(pend_rec.bz));
            check("period_cnt_after_carry", int'(period_cnt), pend_rec.pc);
            pend = 1'b0;
        end else if (step_pulse) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_step_pulse: got 1, expected 0 (t=%0t)", $time);
        end
        if (busy && !busy_q) cyc = 0;
        else cyc++;
        busy_q = busy;
        if (busy && co) begin
            ncarry++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_carry: got carry with SW_out=%0d, expected none (t=%0t)", SW_out, $time);
            end else begin
                cur = sb.pop_front();
                $display("carry %0d: period %0d SW_out %0d ld %0d", ncarry, cyc, SW_out, ld);
                check("carry_period", cyc, cur.period);
                check("ld_at_carry", int'(ld), 1);
                check("SW_out_at_carry", int'(SW_out), cur.sw);
                pend_rec = cur;
                pend = 1'b1;
            end
            cyc = 0;
        end
    end

    task automatic start_sweep(input int sc, input int ec, input int dw, input bit lp);
        start_code = 3'(sc);
        end_code   = 3'(ec);
        dwell      = 8'(dw);
        loop_en    = lp;
        start      = 1'b1;
        @(posedge RO_Clk); #1;
        start      = 1'b0;
        $display("sweep start %0d..%0d dwell %0d loop %0d", sc, ec, dw, lp);
    endtask

    task automatic wait_sb(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge RO_Clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL carry_timeout: got %0d carries outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge RO_Clk);
        @(posedge RO_Clk); #1;
    endtask

    typedef struct {
        int sc;
        bit st;
        bit sp;
        int exp_sw;
        bit exp_busy;
    } vec_t;

    vec_t vt[6];

    initial begin
        int k;
        vt[0] = '{sc: 3, st: 0, sp: 0, exp_sw: 3, exp_busy: 0};
        vt[1] = '{sc: 6, st: 0, sp: 0, exp_sw: 6, exp_busy: 0};
        vt[2] = '{sc: 0, st: 0, sp: 1, exp_sw: 0, exp_busy: 0};
        vt[3] = '{sc: 7, st: 0, sp: 0, exp_sw: 7, exp_busy: 0};
        vt[4] = '{sc: 2, st: 1, sp: 1, exp_sw: 2, exp_busy: 0};
        vt[5] = '{sc: 5, st: 0, sp: 0, exp_sw: 5, exp_busy: 0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        start_code = 3'd0; end_code = 3'd0; dwell = 8'd0;
        repeat (3) @(posedge RO_Clk);
        @(negedge RO_Clk);
        check("reset_ld", int'(ld), 1);
        check("reset_SW_out", int'(SW_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_step_pulse", int'(step_pulse), 0);
        check("reset_period_cnt", int'(period_cnt), 0);
        @(posedge RO_Clk); #1;
        rst_n = 1'b1;

        // Idle: SW_out follows start_code live; stop beats start.
        for (int i = 0; i < 6; i++) begin
            start_code = 3'(vt[i].sc);
            start      = vt[i].st;
            stop       = vt[i].sp;
            @(posedge RO_Clk); #1;
            start = 1'b0;
            stop  = 1'b0;
            $display("idle vector %0d: start_code %0d SW_out %0d busy %0d", i, vt[i].sc, SW_out, busy);
            check("idle_SW_out", int'(SW_out), vt[i].exp_sw);
            check("idle_ld", int'(ld), 1);
            check("idle_busy", int'(busy), int'(vt[i].exp_busy));
            check("idle_done", int'(done), 0);
        end

        // Up sweep 5..7, dwell 2; inputs scrambled while busy must be ignored.
        push(192, 5, 0, 0, 1, 1);
        push(192, 6, 1, 0, 1, 0);
        push(128, 6, 0, 0, 1, 1);
        push(128, 7, 1, 0, 1, 0);
        push(64,  7, 0, 0, 1, 1);
        push(64,  7, 0, 1, 0, 0);
        start_sweep(5, 7, 2, 0);
        start_code = 3'd1; end_code = 3'd2; dwell = 8'd9;
        wait_sb(3000);
        check("done_state_done", int'(done), 1);
        check("done_state_SW_out", int'(SW_out), 7);
        check("done_state_ld", int'(ld), 1);

        // dwell=0 acts as dwell=1; started directly from DONE.
        push(320, 4, 1, 0, 1, 0);
        push(256, 4, 0, 1, 0, 0);
        start_sweep(3, 4, 0, 0);
        wait_sb(3000);
        check("dwell0_done", int'(done), 1);
        stop = 1'b1;
        @(posedge RO_Clk); #1;
        stop = 1'b0;
        check("stop_from_done_busy", int'(busy), 0);
        check("stop_from_done_done", int'(done), 0);
        check("stop_from_done_SW_out", int'(SW_out), 3);

        // Down sweep with wrap 2,1,0,2,...
        push(384, 1, 1, 0, 1, 0);
        push(448, 0, 1, 0, 1, 0);
        push(512, 2, 1, 0, 1, 0);
        push(384, 1, 1, 0, 1, 0);
        start_sweep(2, 0, 1, 1);
        wait_sb(5000);
        stop = 1'b1;
        @(posedge RO_Clk); #1;
        stop = 1'b0;
        check("loop_stop_busy", int'(busy), 0);
        check("loop_stop_done", int'(done), 0);
        check("loop_stop_period_cnt", int'(period_cnt), 0);
        check("loop_stop_SW_out", int'(SW_out), 2);

        // stop coincident with a final carry at code 5.
        push(192, 5, 0, 0, 0, 0);
        start_sweep(5, 7, 1, 0);
        k = 0;
        while (!co && k < 1000) begin
            @(posedge RO_Clk); #1;
            k++;
        end
        check("carry_reached_for_stop", int'(co), 1);
        stop = 1'b1;
        @(posedge RO_Clk); #1;
        stop = 1'b0;
        wait_sb(100);
        check("stop_carry_code_reg", int'(dut.code_reg), 5);
        check("stop_carry_ld", int'(ld), 1);
        check("stop_carry_busy", int'(busy), 0);

        // Asynchronous reset mid-RUN at code 6.
        push(192, 6, 1, 0, 1, 0);
        start_sweep(5, 7, 1, 0);
        wait_sb(1000);
        repeat (20) @(posedge RO_Clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_ld", int'(ld), 1);
        check("midrun_reset_SW_out", int'(SW_out), 5);
        check("midrun_reset_busy", int'(busy), 0);
        check("midrun_reset_done", int'(done), 0);
        check("midrun_reset_step_pulse", int'(step_pulse), 0);
        check("midrun_reset_period_cnt", int'(period_cnt), 0);
        check("midrun_reset_code_reg", int'(dut.code_reg), 0);
        @(posedge RO_Clk); #1;
        rst_n = 1'b1;
        push(192, 6, 1, 0, 1, 0);
        push(128, 7, 1, 0, 1, 0);
        push(64,  7, 0, 1, 0, 0);
        start_sweep(5, 7, 1, 0);
        wait_sb(2000);
        check("after_reset_sweep_done", int'(done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish by t=%0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
